regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file, the next generation of the single-port REGA/REGB register file in the datapath. It provides one write port and NREAD independent combinational read ports. A sequential clear engine wipes one entry per cycle after reset or on request, and raises Busy while it runs. Writes can optionally be forwarded to same-cycle reads.

## Interface
- n, 32: data width of each register.
- widthbit, 4: address width; depth is 2**widthbit entries.
- NREAD, 2: number of read ports (1..4).
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-low reset; sampled on the rising Clk edge.
- RegWrite  input  1  write request for the current cycle.
- WAddr  input  widthbit  write address.
- Din  input  n  write data.
- Clear  input  1  request a full clear sequence.
- RAddr  input  NREAD*widthbit  packed read addresses; port i uses bits [i*widthbit +: widthbit].
- Qout  output  NREAD*n  packed read data; port i uses bits [i*n +: n].
- Busy  output  1  high while the clear engine is running.
- WErr  output  1  registered one-cycle pulse; high when a write was dropped.

## Operation
- The FSM has two states: IDLE and CLEAR. A pointer Ptr of width widthbit selects the entry being cleared.
- Reset (Rst=0 at an edge):
  - state <= CLEAR, Ptr <= 0, WErr <= 0.
  - Array contents are not touched directly.
- CLEAR state:
  - Each cycle: RF[Ptr] <= 0 and Ptr <= Ptr+1.
  - When Ptr == 2**widthbit-1, the clear completes and state <= IDLE.
  - Ptr wraps to 0 when it increments past the last entry.
- IDLE state:
  - Clear=1 moves to CLEAR with Ptr <= 0.
  - Otherwise, RegWrite=1 performs RF[WAddr] <= Din.
- Dropped writes: if RegWrite=1 while Busy=1, or while Clear=1 in IDLE, the write is discarded and WErr=1 the next cycle. Clear has priority over a write in the same cycle.
- Clear asserted while already in CLEAR is ignored; it does not restart the sweep.
- Busy = (state == CLEAR), decoded combinationally from state.
- Reads:
  - Each read port returns RF[RAddr_i] combinationally.
  - While Busy=1, every Qout port is forced to 0, because uncleared entries are undefined.
- Any number of read ports may address the same entry, or the write address, in the same cycle.
- Reset mid-sweep: the sweep restarts from Ptr=0 and takes a full 2**widthbit cycles after Rst returns high.

## Timing
- Output values during reset and in the first cycle after it:
  - Busy=1.
  - WErr=0.
  - Qout all zeros.
- Clear sweep duration:
  - A sweep occupies exactly 2**widthbit rising edges with Rst=1.
  - With defaults, Busy is high for 16 cycles after reset release and falls after the 16th edge.
- Clear request latency: Clear is sampled at edge k, Busy goes high after edge k and goes low after edge k+2**widthbit.
- Write latency:
  - A write at edge k is visible on Qout after edge k.
  - With bypass compiled in, it is also visible in the same cycle, before edge k.
- WErr is high for exactly the one cycle following the edge where the dropped write was sampled.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When state is IDLE, Clear=0, RegWrite=1 and RAddr_i == WAddr, Qout port i returns Din combinationally, giving write-first behaviour.
  - Forwarding is applied to every read port independently.
- REGFILE_BYPASS_EN undefined:
  - Reads return array contents only, giving read-old-value behaviour; the new value appears after the edge.

## Test plan
- Reset clear: hold Rst=0 for 3 cycles, then release -> Busy=1 for exactly 16 cycles, Qout=0 throughout; after the sweep, reading all 16 addresses returns 0.
- Write/read on two ports: write 0xDEADBEEF to address 5 and 0x12345678 to address 9, then RAddr={9,5} -> port0=0x12345678, port1=0xDEADBEEF.
- Bypass: RegWrite=1, WAddr=3, Din=0xA5A5A5A5, RAddr0=3, old value 0 -> with REGFILE_BYPASS_EN the same-cycle Qout0=0xA5A5A5A5; without it Qout0=0 until the edge.
- Clear wins over write: Clear=1 together with RegWrite=1 to address 2 -> WErr=1 for one cycle, Busy rises, and address 2 reads 0 after the sweep.
- Write during sweep: RegWrite=1 at sweep cycle 7 -> WErr pulses, the write is discarded, and Busy timing is unchanged.
- Reset mid-sweep: assert Rst=0 at sweep cycle 10 for one cycle -> the sweep restarts with Ptr=0 and Busy stays high for 16 more cycles.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus interface for regfile_mp: one write port, NREAD packed read ports,
// clear request and status outputs. master drives requests, slave is the register file.
interface regfile_mp_if #(
    parameter int unsigned n        = 32,
    parameter int unsigned widthbit = 4,
    parameter int unsigned NREAD    = 2
);
    logic                      RegWrite;
    logic [widthbit-1:0]       WAddr;
    logic [n-1:0]              Din;
    logic                      Clear;
    logic [NREAD*widthbit-1:0] RAddr;
    logic [NREAD*n-1:0]        Qout;
    logic                      Busy;
    logic                      WErr;

    modport master (
        output RegWrite,
        output WAddr,
        output Din,
        output Clear,
        output RAddr,
        input  Qout,
        input  Busy,
        input  WErr
    );

    modport slave (
        input  RegWrite,
        input  WAddr,
        input  Din,
        input  Clear,
        input  RAddr,
        output Qout,
        output Busy,
        output WErr
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: 2**widthbit x n register file, one write port, NREAD combinational read ports.
// A sweep engine zeroes one entry per cycle after reset or on Clear; Busy is high meanwhile
// and all read ports return 0. Writes that cannot be honoured are dropped and flagged on WErr.
// Optional feature: define REGFILE_BYPASS_EN for write-first forwarding of Din to matching
// read ports in the same cycle.
module regfile_mp #(
    parameter int unsigned n        = 32,
    parameter int unsigned widthbit = 4,
    parameter int unsigned NREAD    = 2
) (
    input logic         Clk,
    input logic         Rst,
    regfile_mp_if.slave bus
);

    localparam int unsigned Depth = 2 ** widthbit;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StClear = 1'b1;

    localparam logic [widthbit-1:0] PtrLast = {widthbit{1'b1}};

    logic [0:0]          state_q, state_d;
    logic [widthbit-1:0] ptr_q, ptr_d;
    logic                werr_q, werr_d;
    logic [n-1:0]        rf_q [Depth];
    logic [n-1:0]        rf_d [Depth];

    logic                busy;
    logic                wr_en;
    logic [NREAD*n-1:0]  qout;

    assign busy = (state_q == StClear);

    // Sweep sequencing, write acceptance and dropped-write detection.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        werr_d  = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.Clear) begin
                    // Clear wins over a same-cycle write; the write is reported as dropped.
                    state_d = StClear;
                    ptr_d   = '0;
                    werr_d  = bus.RegWrite;
                end else begin
                    wr_en = bus.RegWrite;
                end
            end
            StClear: begin
                // Clear requests here are ignored so the sweep is never restarted.
                ptr_d  = ptr_q + 1'b1;
                werr_d = bus.RegWrite;
                if (ptr_q == PtrLast) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StClear;
                ptr_d   = '0;
            end
        endcase
    end

    // Array next state: sweep zeroes the pointed entry, otherwise an accepted write lands.
    always_comb begin
        rf_d = rf_q;
        if (busy) begin
            rf_d[ptr_q] = '0;
        end else if (wr_en) begin
            rf_d[bus.WAddr] = bus.Din;
        end
    end

    // Control state with synchronous active-low reset that restarts the sweep.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= StClear;
            ptr_q   <= '0;
            werr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            werr_q  <= werr_d;
        end
    end

    // Storage is never reset directly; the sweep is what makes it defined.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rf_q <= rf_d;
        end
    end

    // Read ports: masked while sweeping, optionally forwarding same-cycle write data.
    always_comb begin
        qout = '0;
        for (int i = 0; i < int'(NREAD); i++) begin
            logic [widthbit-1:0] raddr;
            raddr = bus.RAddr[i*widthbit +: widthbit];
            if (busy) begin
                qout[i*n +: n] = '0;
            end else begin
`ifdef REGFILE_BYPASS_EN
                if (!bus.Clear && bus.RegWrite && (raddr == bus.WAddr)) begin
                    qout[i*n +: n] = bus.Din;
                end else begin
                    qout[i*n +: n] = rf_q[raddr];
                end
`else
                qout[i*n +: n] = rf_q[raddr];
`endif
            end
        end
    end

    assign bus.Qout = qout;
    assign bus.Busy = busy;
    assign bus.WErr = werr_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (default parameters, two read ports).
// Stimulus pushes one expected-output record per cycle; a negedge monitor pops and compares.
module tb_regfile_mp;

    localparam int unsigned N  = 32;
    localparam int unsigned WB = 4;
    localparam int unsigned NR = 2;

`ifdef REGFILE_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        busy;
        logic        werr;
        logic        chk_q;
        logic [31:0] q0;
        logic [31:0] q1;
    } exp_t;

    logic Clk;
    logic Rst;
    exp_t sb[$];
    int   tests;
    int   fails;

    regfile_mp_if #(.n(N), .widthbit(WB), .NREAD(NR)) bus ();

    regfile_mp #(.n(N), .widthbit(WB), .NREAD(NR)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish (got timeout, wanted completion)");
        $fatal(1);
    end

    // One cycle: wait for the edge, drive inputs, queue what the outputs must show.
    task automatic cyc(input logic rst, input logic rw, input logic [3:0] wa,
                       input logic [31:0] din, input logic clr, input logic [3:0] ra0,
                       input logic [3:0] ra1, input logic eb, input logic ew,
                       input logic cq, input logic [31:0] eq0, input logic [31:0] eq1,
                       input string nm);
        exp_t e;
        @(posedge Clk);
        #1;
        Rst          = rst;
        bus.RegWrite = rw;
        bus.WAddr    = wa;
        bus.Din      = din;
        bus.Clear    = clr;
        bus.RAddr    = {ra1, ra0};
        e.name  = nm;
        e.busy  = eb;
        e.werr  = ew;
        e.chk_q = cq;
        e.q0    = eq0;
        e.q1    = eq1;
        sb.push_back(e);
    endtask

    // Monitor: outputs are combinational/registered, so every cycle presents a response.
    always @(negedge Clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            if (bus.Busy !== e.busy) begin
                fails++;
                $display("FAIL %s busy: got %b want %b at %0t", e.name, bus.Busy, e.busy, $time);
            end
            tests++;
            if (bus.WErr !== e.werr) begin
                fails++;
                $display("FAIL %s werr: got %b want %b at %0t", e.name, bus.WErr, e.werr, $time);
            end
            if (e.chk_q) begin
                tests++;
                if (bus.Qout !== {e.q1, e.q0}) begin
                    fails++;
                    $display("FAIL %s qout: got %h want %h at %0t", e.name, bus.Qout,
                             {e.q1, e.q0}, $time);
                end
            end
        end
    end

    initial begin
        tests        = 0;
        fails        = 0;
        Rst          = 1'b0;
        bus.RegWrite = 1'b0;
        bus.WAddr    = '0;
        bus.Din      = '0;
        bus.Clear    = 1'b0;
        bus.RAddr    = '0;
        @(posedge Clk);

        // Reset held, then the full sweep after release.
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, "reset_hold");
        for (int i = 0; i < 16; i++)
            cyc(1, 0, 0, 0, 0, 4'(i), 4'(15 - i), 1, 0, 1, 0, 0, "reset_sweep");
        for (int i = 0; i < 8; i++)
            cyc(1, 0, 0, 0, 0, 4'(2 * i), 4'(2 * i + 1), 0, 0, 1, 0, 0, "post_reset_read");

        // Two writes, then dual-port read.
        cyc(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0, 0, "wr5");
        cyc(1, 1, 9, 32'h12345678, 0, 9, 5, 0, 0, 1, Byp ? 32'h12345678 : 32'h0,
            32'hDEADBEEF, "wr9_rd");
        cyc(1, 0, 0, 0, 0, 9, 5, 0, 0, 1, 32'h12345678, 32'hDEADBEEF, "rd_9_5");

        // Same-cycle forwarding (or old value without it).
        cyc(1, 1, 3, 32'hA5A5A5A5, 0, 3, 3, 0, 0, 1, Byp ? 32'hA5A5A5A5 : 32'h0,
            Byp ? 32'hA5A5A5A5 : 32'h0, "bypass");
        cyc(1, 0, 0, 0, 0, 3, 9, 0, 0, 1, 32'hA5A5A5A5, 32'h12345678, "rd_3");

        // Clear beats a same-cycle write to address 2.
        cyc(1, 1, 2, 32'h11111111, 1, 2, 5, 0, 0, 1, 0, 32'hDEADBEEF, "clr_vs_wr");
        for (int s = 0; s < 16; s++)
            cyc(1, 0, 0, 0, 0, 2, 5, 1, (s == 0), 1, 0, 0, "clr_sweep");
        cyc(1, 0, 0, 0, 0, 2, 5, 0, 0, 1, 0, 0, "after_clr");
        cyc(1, 0, 0, 0, 0, 3, 9, 0, 0, 1, 0, 0, "after_clr2");

        // Write dropped at sweep cycle 7; Clear at cycle 3 must not restart the sweep.
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, "clr2_start");
        for (int s = 0; s < 16; s++)
            cyc(1, (s == 7), 4, 32'hCAFEF00D, (s == 3), 4, 7, 1, (s == 8), 1, 0, 0,
                "wr_in_sweep");
        cyc(1, 0, 0, 0, 0, 4, 7, 0, 0, 1, 0, 0, "dropped_wr_rd");

        // Reset at sweep cycle 10 restarts a full 16-cycle sweep.
        cyc(1, 1, 15, 32'h0BADF00D, 0, 15, 0, 0, 0, 1, Byp ? 32'h0BADF00D : 32'h0, 0, "wr15");
        cyc(1, 0, 0, 0, 1, 15, 0, 0, 0, 1, 32'h0BADF00D, 0, "clr3_start");
        for (int s = 0; s < 10; s++)
            cyc(1, 0, 0, 0, 0, 15, 0, 1, 0, 1, 0, 0, "pre_rst_sweep");
        cyc(0, 0, 0, 0, 0, 15, 0, 1, 0, 1, 0, 0, "mid_rst");
        for (int s = 0; s < 16; s++)
            cyc(1, 0, 0, 0, 0, 15, 0, 1, 0, 1, 0, 0, "restarted_sweep");
        cyc(1, 0, 0, 0, 0, 15, 0, 0, 0, 1, 0, 0, "after_restart");

        // Boundary addresses after recovery.
        cyc(1, 1, 0, 32'h0000FFFF, 0, 1, 1, 0, 0, 1, 0, 0, "wr0");
        cyc(1, 1, 15, 32'hFFFF0000, 0, 0, 0, 0, 0, 1, 32'h0000FFFF, 32'h0000FFFF, "wr15b");
        cyc(1, 0, 0, 0, 0, 15, 0, 0, 0, 1, 32'hFFFF0000, 32'h0000FFFF, "rd_0_15");

        @(negedge Clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
